rom_read_sequencer: RTL and testbench

Sequences reads from the external parallel ROM under test. It steps a 9-bit address from 0 up to a programmable last address, drives the ROM chip-select and output-enable strobes with a programmable access delay, and captures each data byte. Each address/data pair is held long enough for the seven-segment address display and downstream logging to consume it. The block is the single owner of the ROM bus and the source of the display's `address_line`.

---
 rtl/rom_read_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_rom_read_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_read_sequencer.sv
`timescale 1ns/1ps
// rom_read_sequencer
// Walks a parallel ROM from address 0 up to LAST_ADDRESS, driving chip-select
// and output-enable with a programmable access delay, capturing each byte and
// holding the address/data pair for the display and logger.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous reset, active low
//   i_start        begin a scan (honoured in IDLE/DONE only)
//   i_single_step  1 = wait for i_step after each word, 0 = auto dwell
//   i_step         advance to the next address (step-mode HOLD only)
//   i_abort        terminate the scan, highest priority after reset
//   i_rom_data     ROM data bus
//   o_rom_address  ROM address bus
//   o_rom_cs_n     ROM chip select, active low
//   o_rom_oe_n     ROM output enable, active low
//   o_address_line address of the last captured word
//   o_data_out     last captured byte
//   o_data_valid   one-cycle pulse when o_data_out/o_address_line update
//   o_busy         high in every state except IDLE and DONE
//   o_done         high once LAST_ADDRESS is captured, until the next start
module rom_read_sequencer #(
    parameter int unsigned ADDRESS_WIDTH = 9,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ACCESS_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned LAST_ADDRESS  = 511
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic                     i_single_step,
    input  logic                     i_step,
    input  logic                     i_abort,
    input  logic [DATA_WIDTH-1:0]    i_rom_data,
    output logic [ADDRESS_WIDTH-1:0] o_rom_address,
    output logic                     o_rom_cs_n,
    output logic                     o_rom_oe_n,
    output logic [ADDRESS_WIDTH-1:0] o_address_line,
    output logic [DATA_WIDTH-1:0]    o_data_out,
    output logic                     o_data_valid,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int unsigned CNT_MAX = (ACCESS_CYCLES > HOLD_CYCLES) ? ACCESS_CYCLES : HOLD_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]         ACCESS_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0]         HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST   = ADDRESS_WIDTH'(LAST_ADDRESS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_ACCESS  = 3'd2,
        S_CAPTURE = 3'd3,
        S_HOLD    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_next_cnt;
    logic [ADDRESS_WIDTH-1:0] r_rom_address;
    logic [ADDRESS_WIDTH-1:0] w_next_address;
    logic                     w_capture;
    logic                     w_advance;
    logic                     w_scan_active;

    logic                     w_cs_n;
    logic                     w_oe_n;
    logic                     w_data_valid;
    logic                     w_busy;
    logic                     w_done;

    logic                     r_rom_cs_n;
    logic                     r_rom_oe_n;
    logic                     r_data_valid;
    logic                     r_busy;
    logic                     r_done;
    logic [ADDRESS_WIDTH-1:0] r_address_line;
    logic [DATA_WIDTH-1:0]    r_data_out;

    assign w_scan_active = (r_state != S_IDLE) && (r_state != S_DONE);

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, dwell counter, address and registered-output next values
    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_next_address = r_rom_address;
        w_capture      = 1'b0;
        w_advance      = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start && !i_abort) begin
                    w_next_state   = S_SETUP;
                    w_next_address = '0;
                end
            end
            S_SETUP: begin
                w_next_state = S_ACCESS;
                w_next_cnt   = '0;
            end
            S_ACCESS: begin
                if (r_cnt == ACCESS_LAST) begin
                    w_next_state = S_CAPTURE;
                    w_capture    = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                w_next_state = S_HOLD;
                w_next_cnt   = '0;
            end
            S_HOLD: begin
                // Step mode freezes the dwell count; auto mode resumes from it.
                if (i_single_step) begin
                    w_advance = i_step;
                end else if (r_cnt == HOLD_LAST) begin
                    w_advance = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // Advance decision on the HOLD exit edge; the address never wraps.
        if (w_advance) begin
            if (r_rom_address == ADDR_LAST) begin
                w_next_state = S_DONE;
            end else begin
                w_next_state   = S_SETUP;
                w_next_address = r_rom_address + ADDRESS_WIDTH'(1);
            end
        end

        // Abort overrides everything, including a capture on this edge.
        if (i_abort && w_scan_active) begin
            w_next_state   = S_IDLE;
            w_next_cnt     = r_cnt;
            w_next_address = r_rom_address;
            w_capture      = 1'b0;
        end
    end

    // Outputs are derived from the next state so they register alongside it.
    always_comb begin
        w_cs_n       = 1'b1;
        w_oe_n       = 1'b1;
        w_data_valid = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (w_next_state)
            S_SETUP:   begin w_cs_n = 1'b0; w_busy = 1'b1; end
            S_ACCESS:  begin w_cs_n = 1'b0; w_oe_n = 1'b0; w_busy = 1'b1; end
            S_CAPTURE: begin w_cs_n = 1'b0; w_data_valid = 1'b1; w_busy = 1'b1; end
            S_HOLD:    begin w_busy = 1'b1; end
            S_DONE:    begin w_done = 1'b1; end
            default:   begin end
        endcase
    end

    // Counter, address and output registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt          <= '0;
            r_rom_address  <= '0;
            r_rom_cs_n     <= 1'b1;
            r_rom_oe_n     <= 1'b1;
            r_data_valid   <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_address_line <= '0;
            r_data_out     <= '0;
        end else begin
            r_cnt         <= w_next_cnt;
            r_rom_address <= w_next_address;
            r_rom_cs_n    <= w_cs_n;
            r_rom_oe_n    <= w_oe_n;
            r_data_valid  <= w_data_valid;
            r_busy        <= w_busy;
            r_done        <= w_done;
            if (w_capture) begin
                r_data_out     <= i_rom_data;
                r_address_line <= r_rom_address;
            end
        end
    end

    assign o_rom_address  = r_rom_address;
    assign o_rom_cs_n     = r_rom_cs_n;
    assign o_rom_oe_n     = r_rom_oe_n;
    assign o_address_line = r_address_line;
    assign o_data_out     = r_data_out;
    assign o_data_valid   = r_data_valid;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule

// File: tb/tb_rom_read_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for rom_read_sequencer with a 4-word ROM (LAST_ADDRESS=3).
module tb_rom_read_sequencer;

    localparam int AW   = 9;
    localparam int DW   = 8;
    localparam int AC   = 4;
    localparam int HC   = 16;
    localparam int LAST = 3;
    localparam int PER  = 2 + AC + HC;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, single_step, step, abort;
    logic [DW-1:0] rom_data;
    logic [AW-1:0] rom_address, address_line;
    logic          rom_cs_n, rom_oe_n;
    logic [DW-1:0] data_out;
    logic          data_valid, busy, done;

    rom_read_sequencer #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(AC),
        .HOLD_CYCLES(HC), .LAST_ADDRESS(LAST)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_single_step(single_step),
        .i_step(step), .i_abort(abort), .i_rom_data(rom_data),
        .o_rom_address(rom_address), .o_rom_cs_n(rom_cs_n), .o_rom_oe_n(rom_oe_n),
        .o_address_line(address_line), .o_data_out(data_out),
        .o_data_valid(data_valid), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ROM model: data is only valid once OE has been low for the full access time.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int oe_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         oe_cnt <= 0;
        else if (!rom_oe_n) oe_cnt <= oe_cnt + 1;
        else                oe_cnt <= 0;
    end
    assign rom_data = (!rom_cs_n && !rom_oe_n && oe_cnt >= AC - 1) ? mem[rom_address] : 8'hEE;

    // Scoreboard
    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;
    exp_t q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) check("addr_bound", int'(rom_address) <= LAST, 1);
            if (data_valid) begin
                if (q.size() == 0) begin
                    check("valid_with_empty_queue", q.size(), 1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("capture_addr", address_line, e.addr);
                    check("capture_data", data_out, e.data);
                    if (e.cyc >= 0) check("capture_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic fill_xor();
        for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a ^ 8'hA5);
    endtask

    task automatic fill_rand();
        for (int a = 0; a < (1 << AW); a++) mem[a] = DW'($urandom);
    endtask

    // Expected words of a scan started with the start level set at cycle s.
    task automatic push_words(input int s, input int upto, input bit timed, input bit first_timed);
        for (int a = 0; a <= upto; a++) begin
            exp_t e;
            e.addr = a;
            e.data = int'(mem[a]);
            e.cyc  = (timed || (first_timed && a == 0)) ? s + 2 + AC + PER * a : -1;
            q.push_back(e);
        end
    endtask

    task automatic start_scan(input bit mode, output int s);
        start       = 1'b1;
        single_step = mode;
        s           = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input bit rnd);
        int n = 0;
        while (!done && n < bound) begin
            if (rnd) begin
                single_step = ($urandom_range(0, 3) != 0);
                step        = ($urandom_range(0, 2) == 0);
            end else begin
                step = ($urandom_range(0, 4) == 0);
            end
            @(negedge clk);
            n++;
        end
        step = 1'b0;
        check("done_reached", done, 1);
        check("done_busy", busy, 0);
    endtask

    task automatic wait_access2();
        int n = 0;
        while (!(rom_address == 2 && !rom_oe_n) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("reach_access_addr2", n < 500, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst_n = 1'b0; start = 1'b0; single_step = 1'b0; step = 1'b0; abort = 1'b0;
        fill_xor();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rom_address", rom_address, 0);
        check("rst_cs_n", rom_cs_n, 1);
        check("rst_oe_n", rom_oe_n, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", data_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_address_line", address_line, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Auto scan, with stray start pulses while busy
        start_scan(1'b0, s);
        push_words(s, LAST, 1'b1, 1'b1);
        while (cyc < s + 2 + AC + PER * LAST + HC) begin
            start = ($urandom_range(0, 6) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        check("done_before_last_hold_end", done, 0);
        check("busy_in_last_hold", busy, 1);
        @(negedge clk);
        check("done_timing", done, 1);
        check("done_busy_low", busy, 0);
        check("done_cs_n", rom_cs_n, 1);
        check("done_rom_address", rom_address, LAST);
        check("auto_queue_empty", q.size(), 0);

        // Restart from DONE in step mode
        start_scan(1'b1, s);
        check("restart_address", rom_address, 0);
        check("restart_done_clear", done, 0);
        check("restart_setup_cs", rom_cs_n, 0);
        check("restart_setup_oe", rom_oe_n, 1);
        push_words(s, LAST, 1'b0, 1'b1);
        while (cyc < s + 2 + AC + 100) @(negedge clk);
        check("step_wait_line", address_line, 0);
        check("step_wait_cs", rom_cs_n, 1);
        check("step_wait_busy", busy, 1);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check("step_setup_cs", rom_cs_n, 0);
        check("step_setup_oe", rom_oe_n, 1);
        check("step_setup_addr", rom_address, 1);
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (30) @(negedge clk);
        check("step_ignored_line", address_line, 1);
        check("step_ignored_addr", rom_address, 1);
        check("step_ignored_cs", rom_cs_n, 1);
        check("step_ignored_busy", busy, 1);
        wait_done(2000, 1'b0);
        check("step_queue_empty", q.size(), 0);

        // Abort during ACCESS of address 2
        start_scan(1'b0, s);
        push_words(s, 1, 1'b1, 1'b1);
        wait_access2();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_cs", rom_cs_n, 1);
        check("abort_oe", rom_oe_n, 1);
        check("abort_data_out", data_out, 8'hA4);
        check("abort_line", address_line, 1);
        repeat (10) @(negedge clk);
        check("abort_queue_empty", q.size(), 0);
        check("abort_stays_idle", busy, 0);

        // abort together with start in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start_idle_busy", busy, 0);
        check("abort_start_idle_cs", rom_cs_n, 1);

        // Randomized scans with random ROM contents and mode toggling
        for (int r = 0; r < 3; r++) begin
            fill_rand();
            start_scan(1'($urandom_range(0, 1)), s);
            push_words(s, LAST, 1'b0, 1'b0);
            wait_done(3000, 1'b1);
            check("rand_queue_empty", q.size(), 0);
        end
        single_step = 1'b0;

        // Reset in the middle of ACCESS
        fill_xor();
        start_scan(1'b0, s);
        push_words(s, 1, 1'b1, 1'b1);
        wait_access2();
        rst_n = 1'b0;
        #1;
        check("async_rst_cs", rom_cs_n, 1);
        check("async_rst_oe", rom_oe_n, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_addr", rom_address, 0);
        check("async_rst_line", address_line, 0);
        check("async_rst_data", data_out, 0);
        check("async_rst_done", done, 0);
        check("async_rst_queue_empty", q.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
